// File: rtl/rf_exec_ctrl_if.sv
// Bundle of command, register-file and status signals around rf_exec_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface rf_exec_ctrl_if #(
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned BW_ADDR = 5
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [BW_ADDR-1:0] cmd_rs0;
  logic [BW_ADDR-1:0] cmd_rs1;
  logic [BW_ADDR-1:0] cmd_rd;
  logic [BW_ADDR-1:0] rf_rd_addr0;
  logic [BW_ADDR-1:0] rf_rd_addr1;
  logic [BW_DATA-1:0] rf_rd_data0;
  logic [BW_DATA-1:0] rf_rd_data1;
  logic               rf_wr_en;
  logic [BW_ADDR-1:0] rf_wr_addr;
  logic [BW_DATA-1:0] rf_wr_data;
  logic               init_done;
  logic               res_valid;
  logic [BW_DATA-1:0] res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_rs0, cmd_rs1, cmd_rd, rf_rd_data0, rf_rd_data1,
    input  cmd_ready, rf_rd_addr0, rf_rd_addr1, rf_wr_en, rf_wr_addr, rf_wr_data,
           init_done, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs0, cmd_rs1, cmd_rd, rf_rd_data0, rf_rd_data1,
    output cmd_ready, rf_rd_addr0, rf_rd_addr1, rf_wr_en, rf_wr_addr, rf_wr_data,
           init_done, res_valid, res_data
  );
endinterface

// File: rtl/rf_exec_ctrl.sv
// Execution controller in front of a 2R/1W register file: clears it after reset,
// then executes ALU commands with a one-cycle write-back and result forwarding.
module rf_exec_ctrl #(
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned BW_ADDR = 5,
  parameter bit          R0_ZERO = 1'b1
) (
  input logic           i_clk,
  input logic           i_rstn,
  rf_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  localparam logic [BW_ADDR-1:0] CntLast = '1;

  state_e             state_q;
  logic [BW_ADDR-1:0] cnt_q;
  logic               ready_q;
  logic               done_q;
  logic               wb_valid_q;
  logic               res_valid_q;
  logic [BW_ADDR-1:0] wb_addr_q;
  logic [BW_DATA-1:0] wb_data_q;

  logic               accept;
  logic               rd_is_zero;
  logic [BW_DATA-1:0] op_a;
  logic [BW_DATA-1:0] op_b;
  logic [BW_DATA-1:0] result;

  // ready_q is only ever set on entry to StRun, so it doubles as the run qualifier.
  always_comb begin
    accept     = bus.cmd_valid && ready_q;
    rd_is_zero = R0_ZERO && (bus.cmd_rd == '0);
    op_a       = (wb_valid_q && (wb_addr_q == bus.cmd_rs0)) ? wb_data_q : bus.rf_rd_data0;
    op_b       = (wb_valid_q && (wb_addr_q == bus.cmd_rs1)) ? wb_data_q : bus.rf_rd_data1;
    result     = '0;
    unique case (bus.cmd_op)
      2'b00:   result = op_a + op_b;
      2'b01:   result = op_a - op_b;
      2'b10:   result = op_a & op_b;
      2'b11:   result = op_a ^ op_b;
      default: result = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StInit;
          cnt_q   <= '0;
        end
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= StRun;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        StRun:   state_q <= StRun;
        default: state_q <= StIdle;
      endcase

      // Writes to r0 still report a result but neither write nor forward.
      wb_valid_q  <= accept && !rd_is_zero;
      res_valid_q <= accept;
      if (accept) begin
        wb_addr_q <= bus.cmd_rd;
        wb_data_q <= result;
      end
    end
  end

  always_comb begin
    bus.cmd_ready   = ready_q;
    bus.init_done   = done_q;
    bus.rf_rd_addr0 = (state_q == StRun) ? bus.cmd_rs0 : '0;
    bus.rf_rd_addr1 = (state_q == StRun) ? bus.cmd_rs1 : '0;
    bus.rf_wr_en    = (state_q == StInit) || wb_valid_q;
    bus.rf_wr_addr  = (state_q == StInit) ? cnt_q : wb_addr_q;
    bus.rf_wr_data  = (state_q == StInit) ? '0 : wb_data_q;
    bus.res_valid   = res_valid_q;
    bus.res_data    = wb_data_q;
  end

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// Directed bench for rf_exec_ctrl with a behavioural 2R/1W register file attached.
module tb_rf_exec_ctrl;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  rf_exec_ctrl_if #(.BW_DATA(32), .BW_ADDR(5)) bus ();

  rf_exec_ctrl #(.BW_DATA(32), .BW_ADDR(5), .R0_ZERO(1'b1)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  // Register file model; bd_* is a backdoor used only while the DUT is not writing.
  logic [31:0] regs [32];
  logic        bd_en;
  logic [4:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bus.rf_wr_en) regs[bus.rf_wr_addr] <= bus.rf_wr_data;
    else if (bd_en)   regs[bd_addr] <= bd_data;
  end

  assign bus.rf_rd_data0 = regs[bus.rf_rd_addr0];
  assign bus.rf_rd_data1 = regs[bus.rf_rd_addr1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        wr;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with rstn just released #1 after an edge: the next edge is edge 1.
  task automatic sweep_check();
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e <= 32) begin
        chk("sweep_wr_en", 32'(bus.rf_wr_en), 32'd1);
        chk("sweep_addr", 32'(bus.rf_wr_addr), 32'(e - 1));
        chk("sweep_data", bus.rf_wr_data, 32'd0);
        chk("sweep_ready", 32'(bus.cmd_ready), 32'd0);
        chk("sweep_rd_addr0", 32'(bus.rf_rd_addr0), 32'd0);
        chk("sweep_res_valid", 32'(bus.res_valid), 32'd0);
      end else begin
        chk("run_ready", 32'(bus.cmd_ready), 32'd1);
        chk("run_init_done", 32'(bus.init_done), 32'd1);
        chk("run_wr_en", 32'(bus.rf_wr_en), 32'd0);
      end
    end
  endtask

  task automatic check_all_zero();
    int nz;
    nz = 0;
    for (int r = 0; r < 32; r++) if (regs[r] !== 32'd0) nz++;
    chk("rf_nonzero_count", 32'(nz), 32'd0);
  endtask

  initial begin
    int waited;
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bd_en    = 1'b0;
    bd_addr  = '0;
    bd_data  = '0;
    // A pending command during the sweep must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_rs0   = 5'd5;
    bus.cmd_rs1   = 5'd6;
    bus.cmd_rd    = 5'd7;

    vecs[0] = '{2'b00, 5'd1,  5'd2,  5'd4,  32'd8,          1'b1};
    vecs[1] = '{2'b01, 5'd4,  5'd1,  5'd5,  32'd3,          1'b1};
    vecs[2] = '{2'b01, 5'd0,  5'd9,  5'd6,  32'hFFFF_FFFF,  1'b1};
    vecs[3] = '{2'b10, 5'd7,  5'd8,  5'd10, 32'hF000_F000,  1'b1};
    vecs[4] = '{2'b11, 5'd7,  5'd8,  5'd11, 32'h0FF0_0FF0,  1'b1};
    vecs[5] = '{2'b00, 5'd1,  5'd2,  5'd0,  32'd8,          1'b0};
    vecs[6] = '{2'b00, 5'd0,  5'd0,  5'd12, 32'd0,          1'b1};
    vecs[7] = '{2'b00, 5'd4,  5'd5,  5'd16, 32'd11,         1'b1};
    vecs[8] = '{2'b00, 5'd16, 5'd16, 5'd17, 32'd22,         1'b1};
    vecs[9] = '{2'b01, 5'd17, 5'd1,  5'd18, 32'd17,         1'b1};

    // Scramble the register file while reset is held.
    for (int r = 0; r < 32; r++) begin
      bd_en   = 1'b1;
      bd_addr = 5'(r);
      bd_data = 32'hA5A5_0000 | 32'(r);
      tick();
    end
    bd_en = 1'b0;
    tick();
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
    chk("rst_wr_data", bus.rf_wr_data, 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_rd_addr0", 32'(bus.rf_rd_addr0), 32'd0);

    rstn = 1'b1;
    sweep_check();
    bus.cmd_valid = 1'b0;
    tick();
    chk("no_accept_before_run", 32'(bus.res_valid), 32'd0);
    check_all_zero();

    // Abort the sweep at address 17 and make sure it restarts from 0.
    rstn = 1'b0;
    tick();
    for (int r = 17; r < 32; r++) begin
      bd_en   = 1'b1;
      bd_addr = 5'(r);
      bd_data = 32'h5A5A_0000 | 32'(r);
      tick();
    end
    bd_en = 1'b0;
    rstn  = 1'b1;
    waited = 0;
    while (!(bus.rf_wr_en && bus.rf_wr_addr == 5'd17) && waited < 40) begin
      tick();
      waited++;
    end
    chk("reach_addr17", 32'(waited < 40), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_wr_en", 32'(bus.rf_wr_en), 32'd0);
    chk("abort_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    rstn = 1'b1;
    sweep_check();
    check_all_zero();

    // Preload operands through the backdoor (the DUT is idle in RUN).
    for (int k = 0; k < 5; k++) begin
      bd_en = 1'b1;
      unique case (k)
        0: begin bd_addr = 5'd1; bd_data = 32'd5;         end
        1: begin bd_addr = 5'd2; bd_data = 32'd3;         end
        2: begin bd_addr = 5'd7; bd_data = 32'hF0F0_F0F0; end
        3: begin bd_addr = 5'd8; bd_data = 32'hFF00_FF00; end
        default: begin bd_addr = 5'd9; bd_data = 32'd1;   end
      endcase
      tick();
    end
    bd_en = 1'b0;

    // Back-to-back commands, one per cycle.
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = vecs[i].op;
      bus.cmd_rs0   = vecs[i].rs0;
      bus.cmd_rs1   = vecs[i].rs1;
      bus.cmd_rd    = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.cmd_ready), 32'd1);
      chk($sformatf("v%0d_rd_addr0", i), 32'(bus.rf_rd_addr0), 32'(vecs[i].rs0));
      chk($sformatf("v%0d_rd_addr1", i), 32'(bus.rf_rd_addr1), 32'(vecs[i].rs1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_res_valid", i), 32'(bus.res_valid), 32'd1);
      chk($sformatf("v%0d_res_data", i), bus.res_data, vecs[i].res);
      chk($sformatf("v%0d_wr_en", i), 32'(bus.rf_wr_en), 32'(vecs[i].wr));
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_wr_addr", i), 32'(bus.rf_wr_addr), 32'(vecs[i].rd));
        chk($sformatf("v%0d_wr_data", i), bus.rf_wr_data, vecs[i].res);
      end
    end
    bus.cmd_valid = 1'b0;
    tick();
    chk("idle_res_valid", 32'(bus.res_valid), 32'd0);
    chk("idle_wr_en", 32'(bus.rf_wr_en), 32'd0);
    tick();
    chk("rf_r4", regs[4], 32'd8);
    chk("rf_r5", regs[5], 32'd3);
    chk("rf_r6", regs[6], 32'hFFFF_FFFF);
    chk("rf_r10", regs[10], 32'hF000_F000);
    chk("rf_r11", regs[11], 32'h0FF0_0FF0);
    chk("rf_r0", regs[0], 32'd0);
    chk("rf_r17", regs[17], 32'd22);
    chk("rf_r18", regs[18], 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
